// File: rtl/fifo1c_rd_stream_if.sv
// FIFO read port plus valid/ready output stream for the fifo1c read-side unloader.
// The master view belongs to the unloader; the slave view belongs to the FIFO and the consumer.
interface fifo1c_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = 108
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_q;
  logic                  fifo_rdreq;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  fifo_empty,
    input  fifo_q,
    input  out_ready,
    output fifo_rdreq,
    output out_data,
    output out_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_q,
    output out_ready,
    input  fifo_rdreq,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/fifo1c_rd_stream.sv
// Read-side unloader for fifo1c FIFOs: issues reads while buffer space (including in-flight
// returns) allows, captures fifo_q after RD_LAT cycles and streams it out on valid/ready.
module fifo1c_rd_stream #(
  parameter int unsigned DATA_WIDTH = 108,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned BUF_DEPTH  = RD_LAT + 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  fifo1c_rd_stream_if.master                 bus,
  input  logic                               flush,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_cnt,
  output logic [31:0]                        xfer_cnt,
  input  logic                               xfer_clr
);

  localparam int unsigned CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam int unsigned ARITH_W = CNT_W + 1;
  localparam int unsigned PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned XFER_W  = 32;

  logic [RD_LAT-1:0]     pipe_q, pipe_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      buf_cnt_q, buf_cnt_d;
  logic [XFER_W-1:0]     xfer_cnt_q, xfer_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];

  logic                  pop;
  logic                  push;
  logic                  rdreq_c;
  logic [ARITH_W-1:0]    inflight;
  logic [ARITH_W-1:0]    level;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Read request: reserve a buffer slot for every outstanding read so returns are never dropped.
  always_comb begin : read_ctrl
    pop      = (buf_cnt_q != '0) & bus.out_ready;
    push     = pipe_q[RD_LAT-1];
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + ARITH_W'(pipe_q[i]);
    end
    level   = ARITH_W'(buf_cnt_q) + inflight - ARITH_W'(pop);
    rdreq_c = !bus.fifo_empty && !flush && (level < ARITH_W'(BUF_DEPTH));
  end

  always_comb begin : next_state
    pipe_d     = '0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    buf_cnt_d  = buf_cnt_q;
    xfer_cnt_d = xfer_cnt_q;
    mem_d      = mem_q;

    if (flush) begin
      // Discard buffered words and in-flight returns; a pop in this cycle does not take effect.
      pipe_d    = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      buf_cnt_d = '0;
    end else begin
      pipe_d[0] = rdreq_c;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        pipe_d[k] = pipe_q[k-1];
      end
      if (push) begin
        mem_d[wr_ptr_q] = bus.fifo_q;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   buf_cnt_d = buf_cnt_q + CNT_W'(1);
        2'b01:   buf_cnt_d = buf_cnt_q - CNT_W'(1);
        default: buf_cnt_d = buf_cnt_q;
      endcase
    end

    if (xfer_clr) begin
      xfer_cnt_d = '0;
    end else if (pop && !flush) begin
      xfer_cnt_d = xfer_cnt_q + XFER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      pipe_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      buf_cnt_q  <= '0;
      xfer_cnt_q <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pipe_q     <= pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      buf_cnt_q  <= buf_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.fifo_rdreq = rdreq_c;
  assign bus.out_valid  = (buf_cnt_q != '0);
  assign bus.out_data   = mem_q[rd_ptr_q];
  assign buf_cnt        = buf_cnt_q;
  assign xfer_cnt       = xfer_cnt_q;

  // Slot reservation guarantees a return always finds space.
  ast_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && (buf_cnt_q == CNT_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_fifo1c_rd_stream.sv
// Directed bench for fifo1c_rd_stream: an RD_LAT=1 instance and an RD_LAT=3/BUF_DEPTH=4
// instance, each fed by a behavioural FIFO with matching read latency.
module tb_fifo1c_rd_stream;
  localparam int unsigned DW = 108;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo1c_rd_stream_if #(.DATA_WIDTH(DW)) ia ();
  fifo1c_rd_stream_if #(.DATA_WIDTH(DW)) ib ();

  logic          a_flush = 1'b0, a_xfer_clr = 1'b0, b_flush = 1'b0, b_xfer_clr = 1'b0;
  logic [1:0]    a_buf_cnt;
  logic [2:0]    b_buf_cnt;
  logic [31:0]   a_xfer_cnt, b_xfer_cnt;

  fifo1c_rd_stream #(.DATA_WIDTH(DW), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ia), .flush(a_flush),
    .buf_cnt(a_buf_cnt), .xfer_cnt(a_xfer_cnt), .xfer_clr(a_xfer_clr));

  fifo1c_rd_stream #(.DATA_WIDTH(DW), .RD_LAT(3), .BUF_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ib), .flush(b_flush),
    .buf_cnt(b_buf_cnt), .xfer_cnt(b_xfer_cnt), .xfer_clr(b_xfer_clr));

  // Behavioural FIFOs: empty is registered, q returns RD_LAT edges after the request edge.
  logic [DW-1:0] a_mem[$];
  logic [DW-1:0] b_mem[$];
  logic          a_empty = 1'b1, b_empty = 1'b1;
  logic [DW-1:0] a_q = '0, b_q = '0, b_p0 = '0, b_p1 = '0;
  logic          a_ready = 1'b0, b_ready = 1'b0;
  bit            a_underflow = 1'b0, b_underflow = 1'b0;
  int            a_rdreqs = 0;

  assign ia.fifo_empty = a_empty;
  assign ia.fifo_q     = a_q;
  assign ia.out_ready  = a_ready;
  assign ib.fifo_empty = b_empty;
  assign ib.fifo_q     = b_q;
  assign ib.out_ready  = b_ready;

  always @(posedge clk) begin
    if (ia.fifo_rdreq) begin
      a_rdreqs <= a_rdreqs + 1;
      if (a_mem.size() == 0) a_underflow <= 1'b1;
      else                   a_q <= a_mem.pop_front();
    end
    a_empty <= (a_mem.size() == 0);
  end

  always @(posedge clk) begin
    b_p1 <= b_p0;
    b_q  <= b_p1;
    if (ib.fifo_rdreq) begin
      if (b_mem.size() == 0) b_underflow <= 1'b1;
      else                   b_p0 <= b_mem.pop_front();
    end
    b_empty <= (b_mem.size() == 0);
  end

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (a_buf_cnt !== 2'd0) begin errors++; $display("FAIL reset_a_buf_cnt: got %0d expected 0", a_buf_cnt); end
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b expected 0", ia.out_valid); end
    checks++; if (ia.out_data !== '0) begin errors++; $display("FAIL reset_a_data: got %h expected 0", ia.out_data); end
    checks++; if (a_xfer_cnt !== 32'd0) begin errors++; $display("FAIL reset_a_xfer: got %0d expected 0", a_xfer_cnt); end
    checks++; if (b_buf_cnt !== 3'd0) begin errors++; $display("FAIL reset_b_buf_cnt: got %0d expected 0", b_buf_cnt); end
    checks++; if (ib.out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b expected 0", ib.out_valid); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    logic exp_rd, exp_v;
    a_ready = 1'b1;
    for (int v = 1; v <= 8; v++) a_mem.push_back(DW'(v));
    tick();
    for (int c = 0; c < 10; c++) begin
      exp_rd = (c <= 7);
      exp_v  = (c >= 2);
      checks++; if (ia.fifo_rdreq !== exp_rd) begin errors++; $display("FAIL lat_rdreq c%0d: got %b expected %b", c, ia.fifo_rdreq, exp_rd); end
      checks++; if (ia.out_valid !== exp_v) begin errors++; $display("FAIL lat_valid c%0d: got %b expected %b", c, ia.out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (ia.out_data !== DW'(c - 1)) begin errors++; $display("FAIL lat_data c%0d: got %h expected %h", c, ia.out_data, DW'(c - 1)); end
      end
      tick();
    end
    checks++; if (a_xfer_cnt !== 32'd8) begin errors++; $display("FAIL lat_xfer: got %0d expected 8", a_xfer_cnt); end
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL lat_idle: got %b expected 0", ia.out_valid); end
    checks++; if (a_underflow !== 1'b0) begin errors++; $display("FAIL lat_underflow: got %b expected 0", a_underflow); end
  endtask

  task automatic test_backpressure();
    int r0;
    int idx;
    a_ready = 1'b0;
    r0 = a_rdreqs;
    for (int i = 0; i < 10; i++) a_mem.push_back(DW'(32'h100 + i));
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ia.out_valid) begin
        checks++; if (ia.out_data !== DW'(32'h100)) begin errors++; $display("FAIL bp_stable c%0d: got %h expected 100", c, ia.out_data); end
      end
    end
    checks++; if (a_rdreqs - r0 !== 2) begin errors++; $display("FAIL bp_rdreqs: got %0d expected 2", a_rdreqs - r0); end
    checks++; if (a_buf_cnt !== 2'd2) begin errors++; $display("FAIL bp_buf_cnt: got %0d expected 2", a_buf_cnt); end
    checks++; if (ia.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", ia.out_valid); end
    a_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 40 && idx < 10; c++) begin
      if (ia.out_valid) begin
        checks++; if (ia.out_data !== DW'(32'h100 + idx)) begin errors++; $display("FAIL bp_order %0d: got %h expected %h", idx, ia.out_data, DW'(32'h100 + idx)); end
        idx++;
      end
      tick();
    end
    checks++; if (idx !== 10) begin errors++; $display("FAIL bp_count: got %0d words expected 10", idx); end
    checks++; if (a_xfer_cnt !== 32'd18) begin errors++; $display("FAIL bp_xfer: got %0d expected 18", a_xfer_cnt); end
    tick();
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0", ia.out_valid); end
  endtask

  task automatic test_single_word();
    a_ready = 1'b1;
    a_mem.push_back(DW'(32'hABC));
    tick();
    checks++; if (ia.fifo_rdreq !== 1'b1) begin errors++; $display("FAIL single_rdreq: got %b expected 1", ia.fifo_rdreq); end
    tick();
    checks++; if (ia.fifo_empty !== 1'b1 || ia.fifo_rdreq !== 1'b0) begin errors++; $display("FAIL single_drop: empty %b rdreq %b expected 1 0", ia.fifo_empty, ia.fifo_rdreq); end
    tick();
    checks++; if (ia.out_valid !== 1'b1 || ia.out_data !== DW'(32'hABC)) begin errors++; $display("FAIL single_word: valid %b data %h expected 1 abc", ia.out_valid, ia.out_data); end
    tick();
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", ia.out_valid); end
    repeat (3) tick();
    checks++; if (ia.out_valid !== 1'b0 || ia.fifo_rdreq !== 1'b0) begin errors++; $display("FAIL single_quiet: valid %b rdreq %b expected 0 0", ia.out_valid, ia.fifo_rdreq); end
    checks++; if (a_underflow !== 1'b0) begin errors++; $display("FAIL single_underflow: got %b expected 0", a_underflow); end
  endtask

  task automatic test_xfer_cnt();
    a_ready = 1'b0;
    force u_a.xfer_cnt_q = 32'hFFFF_FFFF;
    tick();
    release u_a.xfer_cnt_q;
    #1;
    checks++; if (a_xfer_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL xfer_preload: got %h expected ffffffff", a_xfer_cnt); end
    a_mem.push_back(DW'(32'h700));
    a_mem.push_back(DW'(32'h701));
    repeat (6) tick();
    a_ready = 1'b1;
    tick();
    checks++; if (a_xfer_cnt !== 32'd0) begin errors++; $display("FAIL xfer_wrap: got %h expected 0", a_xfer_cnt); end
    checks++; if (ia.out_valid !== 1'b1 || ia.out_data !== DW'(32'h701)) begin errors++; $display("FAIL xfer_next: valid %b data %h expected 1 701", ia.out_valid, ia.out_data); end
    a_xfer_clr = 1'b1;
    tick();
    a_xfer_clr = 1'b0;
    checks++; if (a_xfer_cnt !== 32'd0) begin errors++; $display("FAIL xfer_clr_pop: got %0d expected 0", a_xfer_cnt); end
    checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL xfer_drained: got %b expected 0", ia.out_valid); end
  endtask

  task automatic test_random_stream();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] w;
    int idx;
    for (int i = 0; i < 1000; i++) begin
      w = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
      exp_q.push_back(w);
      b_mem.push_back(w);
    end
    idx = 0;
    for (int c = 0; c < 8000 && idx < 1000; c++) begin
      b_ready = 1'($urandom_range(0, 1));
      #1;
      if (ib.out_valid && b_ready) begin
        checks++; if (ib.out_data !== exp_q[idx]) begin errors++; $display("FAIL rand_data %0d: got %h expected %h", idx, ib.out_data, exp_q[idx]); end
        idx++;
      end
      checks++; if (b_buf_cnt > 3'd4) begin errors++; $display("FAIL rand_buf_cnt c%0d: got %0d expected <=4", c, b_buf_cnt); end
      tick();
    end
    b_ready = 1'b0;
    checks++; if (idx !== 1000) begin errors++; $display("FAIL rand_count: got %0d words expected 1000", idx); end
    checks++; if (b_xfer_cnt !== 32'd1000) begin errors++; $display("FAIL rand_xfer: got %0d expected 1000", b_xfer_cnt); end
    checks++; if (b_underflow !== 1'b0) begin errors++; $display("FAIL rand_underflow: got %b expected 0", b_underflow); end
  endtask

  task automatic test_flush();
    b_ready = 1'b0;
    tick();
    b_mem.push_back(DW'(32'h801));
    tick(); tick();
    b_mem.push_back(DW'(32'h802));
    b_mem.push_back(DW'(32'h803));
    b_mem.push_back(DW'(32'h804));
    tick(); tick(); tick();
    checks++; if (b_buf_cnt !== 3'd1 || ib.out_data !== DW'(32'h801)) begin errors++; $display("FAIL flush_pre: cnt %0d data %h expected 1 801", b_buf_cnt, ib.out_data); end
    b_flush = 1'b1;
    #1;
    checks++; if (ib.fifo_rdreq !== 1'b0) begin errors++; $display("FAIL flush_rdreq: got %b expected 0", ib.fifo_rdreq); end
    tick();
    b_flush = 1'b0;
    #1;
    checks++; if (b_buf_cnt !== 3'd0 || ib.out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: cnt %0d valid %b expected 0 0", b_buf_cnt, ib.out_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (ib.out_valid !== 1'b0) begin errors++; $display("FAIL flush_late c%0d: got %b expected 0", c, ib.out_valid); end
    end
    tick();
    checks++; if (ib.out_valid !== 1'b1 || ib.out_data !== DW'(32'h804)) begin errors++; $display("FAIL flush_resume: valid %b data %h expected 1 804", ib.out_valid, ib.out_data); end
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    checks++; if (b_xfer_cnt !== 32'd1001 || ib.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drain: xfer %0d valid %b expected 1001 0", b_xfer_cnt, ib.out_valid); end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] exp2 [2];
    int idx;
    exp2[0] = DW'(32'h503);
    exp2[1] = DW'(32'h504);
    a_ready = 1'b0;
    for (int i = 1; i <= 4; i++) a_mem.push_back(DW'(32'h500 + i));
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if (ia.out_data !== '0 || a_buf_cnt !== 2'd0) begin errors++; $display("FAIL mrst_a: data %h cnt %0d expected 0 0", ia.out_data, a_buf_cnt); end
    checks++; if (b_xfer_cnt !== 32'd0 || ib.out_data !== '0) begin errors++; $display("FAIL mrst_b: xfer %0d data %h expected 0 0", b_xfer_cnt, ib.out_data); end
    tick();
    rst_n = 1'b1;
    a_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 15; c++) begin
      if (ia.out_valid) begin
        checks++;
        if (idx >= 2) begin errors++; $display("FAIL mrst_extra: got %h expected no word", ia.out_data); end
        else if (ia.out_data !== exp2[idx]) begin errors++; $display("FAIL mrst_data %0d: got %h expected %h", idx, ia.out_data, exp2[idx]); end
        idx++;
      end
      tick();
    end
    checks++; if (idx !== 2) begin errors++; $display("FAIL mrst_count: got %0d words expected 2", idx); end
    checks++; if (a_underflow !== 1'b0 || b_underflow !== 1'b0) begin errors++; $display("FAIL underflow: a %b b %b expected 0 0", a_underflow, b_underflow); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_single_word();
    test_xfer_cnt();
    test_random_stream();
    test_flush();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end
endmodule
